// File: rtl/dieukhien_dem_if.sv
// dieukhien_dem_if
//   Groups the signals between the button/switch side and the counter side of
//   the count-control stage.
//   btn_dir, btn_pause : raw push-buttons, active high, asynchronous to clk
//   speed              : raw 2-bit speed switch
//   ud                 : count direction, 0 up / 1 down
//   tick               : one-cycle count-enable strobe
//   paused             : high while counting is on hold
//   master drives the raw inputs; slave is the control stage itself.
interface dieukhien_dem_if;
  logic       btn_dir;
  logic       btn_pause;
  logic [1:0] speed;
  logic       ud;
  logic       tick;
  logic       paused;

  modport master (output btn_dir, btn_pause, speed, input ud, tick, paused);
  modport slave  (input btn_dir, btn_pause, speed, output ud, tick, paused);
endinterface

// File: rtl/dieukhien_dem.sv
// dieukhien_dem
//   Count-control stage that sits in front of an up/down counter. It
//   synchronises and debounces two push-buttons, runs a 4-state run/hold FSM
//   and produces a tick strobe at a switch-selected rate.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dieukhien_dem_if.slave (btn_dir, btn_pause, speed in; ud, tick, paused out)

// Per-button conditioning: 2-flop synchroniser, debouncer, rising-edge press pulse.
module dieukhien_dem_btn #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int            CW       = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;
  logic          level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level;
      // The level is accepted on the DB_CYCLES-th consecutive differing sample;
      // any agreeing sample in between restarts the count.
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // One pulse per accepted rising level; releases produce nothing.
  assign press = level & ~level_d;
endmodule

module dieukhien_dem #(
  parameter int DB_CYCLES = 4,
  parameter int PW        = 24,
  parameter int DIV0      = 2,
  parameter int DIV1      = 4,
  parameter int DIV2      = 8,
  parameter int DIV3      = 16
) (
  input logic            clk,
  input logic            reset,
  dieukhien_dem_if.slave bus
);
  localparam int NUM_BTN = 2;  // [0] = direction, [1] = pause

  localparam logic [PW-1:0] LAST0 = PW'(DIV0 - 1);
  localparam logic [PW-1:0] LAST1 = PW'(DIV1 - 1);
  localparam logic [PW-1:0] LAST2 = PW'(DIV2 - 1);
  localparam logic [PW-1:0] LAST3 = PW'(DIV3 - 1);

  // Encoding {dir,hold}: outputs are taken straight from the state bits.
  typedef enum logic [1:0] {
    RUN_UP  = 2'b00,
    HOLD_UP = 2'b01,
    RUN_DN  = 2'b10,
    HOLD_DN = 2'b11
  } state_t;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] press;
  state_t             state;
  logic [1:0]         spd_s1;
  logic [1:0]         spd_sync;
  logic [1:0]         spd_q;
  logic [PW-1:0]      presc;
  logic [PW-1:0]      div_last;
  logic               tick_q;

  assign raw = {bus.btn_pause, bus.btn_dir};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    dieukhien_dem_btn #(.DB_CYCLES(DB_CYCLES)) u_btn (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[gi]),
      .press (press[gi])
    );
  end

  // Run/hold FSM. Each press flips its own state bit, so simultaneous
  // presses apply both toggles (e.g. RUN_UP -> HOLD_DN).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN_UP;
    end else begin
      case (state)
        RUN_UP:  state <= state_t'({press[0],  press[1]});
        HOLD_UP: state <= state_t'({press[0], ~press[1]});
        RUN_DN:  state <= state_t'({~press[0],  press[1]});
        HOLD_DN: state <= state_t'({~press[0], ~press[1]});
        default: state <= RUN_UP;
      endcase
    end
  end

  always_comb begin
    div_last = LAST0;
    case (spd_sync)
      2'b00:   div_last = LAST0;
      2'b01:   div_last = LAST1;
      2'b10:   div_last = LAST2;
      default: div_last = LAST3;
    endcase
  end

  // Prescaler. A speed change restarts the period from zero; hold freezes
  // the count so a resume continues the interrupted period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spd_s1   <= '0;
      spd_sync <= '0;
      spd_q    <= '0;
      presc    <= '0;
      tick_q   <= 1'b0;
    end else begin
      spd_s1   <= bus.speed;
      spd_sync <= spd_s1;
      spd_q    <= spd_sync;
      if (spd_sync != spd_q) begin
        presc  <= '0;
        tick_q <= 1'b0;
      end else if (state[0]) begin
        tick_q <= 1'b0;
      end else if (presc == div_last) begin
        presc  <= '0;
        tick_q <= 1'b1;
      end else begin
        presc  <= presc + 1'b1;
        tick_q <= 1'b0;
      end
    end
  end

  assign bus.ud     = state[1];
  assign bus.paused = state[0];
  assign bus.tick   = tick_q;
endmodule

// File: tb/tb_dieukhien_dem.sv
module tb_dieukhien_dem;
  localparam int DB      = 4;
  localparam int DIVS[4] = '{2, 4, 8, 16};

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   chk_on = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  dieukhien_dem_if bus ();

  dieukhien_dem #(
    .DB_CYCLES(DB), .PW(24), .DIV0(2), .DIV1(4), .DIV2(8), .DIV3(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural reference model ----------------
  // Raw samples are kept in a 2-deep history: the value a button presents to
  // the debouncer is whatever was sampled two edges earlier. Debounce is a
  // run-length of consecutive disagreeing samples; the rate is a phase
  // counter taken modulo the selected period.
  typedef struct packed { bit d; bit p; bit [1:0] s; } smp_t;
  smp_t     hist[$];
  smp_t     syn;
  int       run[2];
  bit       lvl[2], lvl_d[2], sb[2], pr[2];
  bit       m_dir, m_hold, m_tick;
  int       m_ph;
  bit [1:0] m_spd;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      for (int i = 0; i < 2; i++) begin run[i] = 0; lvl[i] = 0; lvl_d[i] = 0; end
      m_dir = 0; m_hold = 0; m_tick = 0; m_ph = 0; m_spd = 0;
    end else begin
      syn   = hist[0];
      sb[0] = syn.d;
      sb[1] = syn.p;
      for (int i = 0; i < 2; i++) begin
        pr[i]    = lvl[i] & ~lvl_d[i];
        lvl_d[i] = lvl[i];
        if (sb[i] != lvl[i]) begin
          run[i]++;
          if (run[i] == DB) begin lvl[i] = sb[i]; run[i] = 0; end
        end else begin
          run[i] = 0;
        end
      end
      if (syn.s != m_spd) begin
        m_spd = syn.s; m_ph = 0; m_tick = 0;
      end else if (m_hold) begin
        m_tick = 0;
      end else begin
        m_tick = (m_ph == DIVS[syn.s] - 1);
        m_ph   = (m_ph + 1) % DIVS[syn.s];
      end
      m_dir  = m_dir ^ pr[0];
      m_hold = m_hold ^ pr[1];
      void'(hist.pop_front());
      hist.push_back({bus.btn_dir, bus.btn_pause, bus.speed});
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("mdl_ud",     int'(bus.ud),     int'(m_dir));
      check("mdl_paused", int'(bus.paused), int'(m_hold));
      check("mdl_tick",   int'(bus.tick),   int'(m_tick));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  typedef struct {
    bit d; bit p; bit [1:0] s; int n;
    bit eud; bit ep; int et;
  } vec_t;
  vec_t vt[9];

  int nt, first_t, second_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {dir, pause, speed, cycles, exp ud, exp paused, exp ticks in window}
    vt[0] = '{0, 0, 2'b00, 16, 0, 0, 8};  // free run at period 2
    vt[1] = '{1, 0, 2'b00, 10, 1, 0, 5};  // dir press
    vt[2] = '{0, 0, 2'b00, 10, 1, 0, 5};  // release: no change
    vt[3] = '{0, 1, 2'b00, 10, 1, 1, 3};  // pause: ticks stop at hold
    vt[4] = '{0, 0, 2'b00, 10, 1, 1, 0};  // release while held
    vt[5] = '{0, 1, 2'b00, 10, 1, 0, 2};  // resume from frozen count
    vt[6] = '{0, 0, 2'b11, 20, 1, 0, 2};  // speed change: clear, then period 16
    vt[7] = '{0, 0, 2'b11, 32, 1, 0, 2};
    vt[8] = '{1, 1, 2'b11, 10, 0, 1, 0};  // simultaneous presses

    bus.btn_dir = 0; bus.btn_pause = 0; bus.speed = 2'b00;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ud",     int'(bus.ud),     0);
    check("rst_paused", int'(bus.paused), 0);
    check("rst_tick",   int'(bus.tick),   0);
    reset  = 1'b0;
    chk_on = 1'b1;

    for (int i = 0; i < 9; i++) begin
      bus.btn_dir = vt[i].d; bus.btn_pause = vt[i].p; bus.speed = vt[i].s;
      nt = 0;
      for (int c = 0; c < vt[i].n; c++) begin
        cyc();
        nt += int'(bus.tick);
      end
      check($sformatf("vec%0d_ud", i),     int'(bus.ud),     int'(vt[i].eud));
      check($sformatf("vec%0d_paused", i), int'(bus.paused), int'(vt[i].ep));
      check($sformatf("vec%0d_ticks", i),  nt,               vt[i].et);
    end

    // Reach HOLD_DN, then reset asynchronously between clock edges.
    bus.btn_dir = 0; bus.btn_pause = 0;
    repeat (10) cyc();
    bus.btn_dir = 1;
    repeat (10) cyc();
    bus.btn_dir = 0; bus.speed = 2'b00;
    repeat (10) cyc();
    check("hold_dn_ud",     int'(bus.ud),     1);
    check("hold_dn_paused", int'(bus.paused), 1);
    reset = 1'b1;
    #1;
    check("async_rst_ud",     int'(bus.ud),     0);
    check("async_rst_paused", int'(bus.paused), 0);
    check("async_rst_tick",   int'(bus.tick),   0);
    #1 reset = 1'b0;
    nt = 0;
    repeat (16) begin cyc(); nt += int'(bus.tick); end
    check("post_rst_ticks", nt, 8);

    // Direction press latency: change lands on the 7th edge.
    bus.btn_dir = 1;
    repeat (6) cyc();
    check("dir_lat_edge6", int'(bus.ud), 0);
    cyc();
    check("dir_lat_edge7", int'(bus.ud), 1);
    bus.btn_dir = 0;
    repeat (10) cyc();
    check("dir_release", int'(bus.ud), 1);

    // Both buttons rising together from RUN_UP.
    do_reset();
    bus.btn_dir = 1; bus.btn_pause = 1;
    repeat (6) cyc();
    check("both_edge6", int'({bus.ud, bus.paused}), 0);
    cyc();
    check("both_edge7", int'({bus.ud, bus.paused}), 3);
    bus.btn_dir = 0; bus.btn_pause = 0;
    repeat (10) cyc();

    // Speed 00 -> 11 while running.
    do_reset();
    bus.speed = 2'b11;
    repeat (3) cyc();
    check("spd_clear_tick", int'(bus.tick), 0);
    nt = 0; first_t = 0; second_t = 0;
    for (int k = 4; k <= 40; k++) begin
      cyc();
      if (bus.tick) begin
        nt++;
        if (nt == 1) first_t = k;
        if (nt == 2) second_t = k;
      end
    end
    check("spd_tick_count",  nt,       2);
    check("spd_first_tick",  first_t,  19);
    check("spd_second_tick", second_t, 35);

    // Random buttons, speed and resets against the model.
    for (int r = 0; r < 3000; r++) begin
      cyc();
      if ($urandom_range(5) == 0)   bus.btn_dir   = ~bus.btn_dir;
      if ($urandom_range(5) == 0)   bus.btn_pause = ~bus.btn_pause;
      if ($urandom_range(39) == 0)  bus.speed     = 2'($urandom_range(3));
      if ($urandom_range(299) == 0) do_reset();
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
